// File: rtl/sub_serial_4bit_pkg.sv
// Shared definitions for the sequential arithmetic blocks (Rechenwerk).
// State encodings are fixed so later serial units can reuse them.
package sub_serial_4bit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rw_state_t;

endpackage

// File: rtl/sub_serial_4bit_if.sv
// Request/result bundle for the bit-serial subtractor.
interface sub_serial_4bit_if #(
  parameter int unsigned N = 4
);
  logic         Start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Busy;
  logic         Done;
  logic [N-1:0] Diff;
  logic         Bout;

  modport master (output Start, A, B, input Busy, Done, Diff, Bout);
  modport slave  (input Start, A, B, output Busy, Done, Diff, Bout);
endinterface

// File: rtl/full_adder.sv
// One-bit full adder slice.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);
  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);
endmodule

// File: rtl/sub_serial_4bit.sv
// Bit-serial subtractor: A - B computed LSB first as A + ~B + 1,
// one full-adder slice per clock; result registered on entry to DONE.
module sub_serial_4bit
  import sub_serial_4bit_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  sub_serial_4bit_if.slave bus
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

  rw_state_t     state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  diff_sr;
  logic [N-1:0]  diff_q;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          busy_q;
  logic          done_q;
  logic          bout_q;
  logic          sum;
  logic          cout;

  full_adder u_fa (
    .A   (a_sr[0]),
    .B   (~b_sr[0]),
    .Cin (carry),
    .Sum (sum),
    .Cout(cout)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      diff_q  <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.Start) begin
            a_sr   <= bus.A;
            b_sr   <= bus.B;
            carry  <= 1'b1;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          diff_sr <= {sum, diff_sr[N-1:1]};
          carry   <= cout;
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            // Final slice: publish the completed word and borrow together.
            diff_q <= {sum, diff_sr[N-1:1]};
            bout_q <= ~cout;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;

endmodule

// File: tb/tb_sub_serial_4bit.sv
// Directed and exhaustive checks for the bit-serial subtractor (N=4).
module tb_sub_serial_4bit;

  localparam int unsigned N = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sub_serial_4bit_if #(.N(N)) bus ();

  sub_serial_4bit #(.N(N)) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] diff;
    logic       bout;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation from IDLE and checks latency, busy span, held output and result.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_diff, input logic exp_bout);
    int lat;
    int busy_cnt;
    logic [3:0] prev_diff;
    logic held_ok;
    prev_diff = bus.Diff;
    held_ok   = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    lat       = 0;
    busy_cnt  = 0;
    while (!bus.Done && lat < 20) begin
      if (bus.Busy) busy_cnt++;
      if (bus.Diff !== prev_diff) held_ok = 1'b0;
      tick();
      lat++;
    end
    check("latency", lat, N);
    check("busy_cycles", busy_cnt, N);
    check("diff_held_during_run", held_ok, 1'b1);
    check("diff", bus.Diff, exp_diff);
    check("bout", bus.Bout, exp_bout);
    check("busy_in_done", bus.Busy, 1'b0);
    tick();
    check("done_single", bus.Done, 1'b0);
    check("diff_hold", bus.Diff, exp_diff);
  endtask

  initial begin
    int ndone;
    int done_at;
    logic [3:0] cap_diff;
    logic cap_bout;
    int times [3];

    total = 0;
    bad   = 0;
    vecs[0] = '{a: 4'd5,  b: 4'd3,  diff: 4'h2, bout: 1'b0};
    vecs[1] = '{a: 4'd3,  b: 4'd5,  diff: 4'hE, bout: 1'b1};
    vecs[2] = '{a: 4'd0,  b: 4'd0,  diff: 4'h0, bout: 1'b0};
    vecs[3] = '{a: 4'd15, b: 4'd15, diff: 4'h0, bout: 1'b0};
    vecs[4] = '{a: 4'd0,  b: 4'd1,  diff: 4'hF, bout: 1'b1};
    vecs[5] = '{a: 4'd15, b: 4'd0,  diff: 4'hF, bout: 1'b0};
    vecs[6] = '{a: 4'd8,  b: 4'd2,  diff: 4'h6, bout: 1'b0};
    vecs[7] = '{a: 4'd7,  b: 4'd12, diff: 4'hB, bout: 1'b1};

    bus.Start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst       = 1'b1;
    #1;
    check("rst_busy", bus.Busy, 1'b0);
    check("rst_done", bus.Done, 1'b0);
    check("rst_diff", bus.Diff, 4'h0);
    check("rst_bout", bus.Bout, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout);

    // Start pulse and input changes during RUN must be ignored.
    bus.A = 4'd9; bus.B = 4'd4; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    ndone = 0; done_at = -1; cap_diff = '0; cap_bout = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1) begin
        bus.Start = 1'b1; bus.A = 4'd1; bus.B = 4'd7;
      end else if (i == 2) begin
        bus.Start = 1'b0;
      end
      if (bus.Done) begin
        ndone++;
        if (done_at < 0) begin
          done_at = i; cap_diff = bus.Diff; cap_bout = bus.Bout;
        end
      end
    end
    check("ign_ndone", ndone, 1);
    check("ign_lat", done_at, N);
    check("ign_diff", cap_diff, 4'h5);
    check("ign_bout", cap_bout, 1'b0);

    // Reset in RUN cycle 2 aborts immediately with no Done.
    bus.A = 4'd9; bus.B = 4'd4; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("abort_busy", bus.Busy, 1'b0);
    check("abort_done", bus.Done, 1'b0);
    check("abort_diff", bus.Diff, 4'h0);
    check("abort_bout", bus.Bout, 1'b0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.Done || bus.Busy) ndone++;
    end
    check("abort_quiet", ndone, 0);
    run_op(4'd8, 4'd2, 4'h6, 1'b0);

    // Start held high: back-to-back results every N+2 cycles.
    bus.A = 4'd12; bus.B = 4'd5; bus.Start = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 30 && ndone < 3; c++) begin
      tick();
      if (bus.Done) begin
        times[ndone] = c;
        ndone++;
        check("b2b_diff", bus.Diff, 4'h7);
      end
    end
    bus.Start = 1'b0;
    check("b2b_count", ndone, 3);
    check("b2b_first", times[0], N + 1);
    check("b2b_gap1", times[1] - times[0], N + 2);
    check("b2b_gap2", times[2] - times[1], N + 2);
    tick();
    tick();
    check("b2b_idle", bus.Busy, 1'b0);

    // Exhaustive against arithmetic reference.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        logic [3:0] ex;
        ex = 4'(x - y);
        run_op(4'(x), 4'(y), ex, (x < y) ? 1'b1 : 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
